// File: rtl/imem_loader.sv
// Byte-stream instruction-memory loader: parses a length-prefixed, XOR-checksummed
// image, writes it word by word, and holds the CPU in reset until the image is verified.
module imem_loader #(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_CHK,
        S_DONE,
        S_ERR
    } state_e;

    localparam logic [CNT_W:0] MAX_WORDS = (CNT_W+1)'(1) << ADDR_W;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  n_q, n_d;
    logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [31:0]       asm_q, asm_d;
    logic [7:0]        xor_q, xor_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              cpu_hold_q, cpu_hold_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              accept;
    logic [CNT_W-1:0]  n_full;
    logic [31:0]       asm_next;

    // in_ready is a pure decode of state and reset; it never looks at in_valid.
    assign in_ready = rst && (state_q == S_LEN_HI || state_q == S_LEN_LO ||
                              state_q == S_DATA   || state_q == S_CHK);
    assign accept   = in_valid && in_ready;
    assign n_full   = {n_q[CNT_W-1:8], in_data};
    assign asm_next = {asm_q[23:0], in_data};

    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        word_cnt_d  = word_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        asm_d       = asm_q;
        xor_d       = xor_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_hold_d  = cpu_hold_q;
        done_d      = done_q;
        err_d       = err_q;
        case (state_q)
            S_LEN_HI: begin
                if (accept) begin
                    n_d[CNT_W-1:8] = in_data;
                    state_d        = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (accept) begin
                    n_d = n_full;
                    if ({1'b0, n_full} > MAX_WORDS) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end else if (n_full == '0) begin
                        state_d = S_CHK;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    asm_d      = asm_next;
                    xor_d      = xor_q ^ in_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        mem_we_d    = 1'b1;
                        mem_wdata_d = asm_next;
                        mem_addr_d  = word_cnt_q[ADDR_W-1:0];
                        word_cnt_d  = word_cnt_q + CNT_W'(1);
                        if (word_cnt_q + CNT_W'(1) == n_q) begin
                            state_d = S_CHK;
                        end
                    end
                end
            end
            S_CHK: begin
                if (accept) begin
                    if (in_data == xor_q) begin
                        state_d    = S_DONE;
                        done_d     = 1'b1;
                        cpu_hold_d = 1'b0;
                    end else begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_LEN_HI;
            n_q         <= '0;
            word_cnt_q  <= '0;
            byte_cnt_q  <= '0;
            asm_q       <= '0;
            xor_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_hold_q  <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            word_cnt_q  <= word_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            asm_q       <= asm_d;
            xor_q       <= xor_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_hold_q  <= cpu_hold_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_hold  = cpu_hold_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed image streams, expected writes queued by the driver
// and checked by an independent write monitor.
module tb_imem_loader;

    localparam int ADDR_W = 10;
    localparam int CNT_W  = 16;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_hold;
    logic              done;
    logic              err;

    imem_loader #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .err       (err)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [ADDR_W+31:0] exp_q[$];
    logic [31:0]        img [0:1023];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // write monitor: every mem_we pulse must match the head of the expected queue
    always @(negedge clk) begin
        logic [ADDR_W+31:0] e;
        if (rst && mem_we) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write",
                         mem_addr, mem_wdata);
            end else begin
                e = exp_q.pop_front();
                check("mem_write", {22'h0, mem_addr, mem_wdata}, {22'h0, e});
            end
        end
        if (rst) check("done_err_exclusive", {63'h0, done & err}, 64'h0);
    end

    // driver tasks; all are entered and left just after a falling edge
    task automatic send_byte(input logic [7:0] b);
        int   waited;
        logic r;
        waited   = 0;
        in_valid = 1'b1;
        in_data  = b;
        forever begin
            #1 r = in_ready;
            @(posedge clk);
            @(negedge clk);
            if (r) break;
            waited++;
            if (waited > 20) begin
                n_checks++;
                n_fail++;
                $display("FAIL byte_accept_timeout: got in_ready 0 for 20 cycles expected 1");
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic offer_refused(input logic [7:0] b, input int cycles);
        in_valid = 1'b1;
        in_data  = b;
        repeat (cycles) begin
            #1 check("in_ready_refused", {63'h0, in_ready}, 64'h0);
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst      = 1'b0;
        in_valid = 1'b0;
        #1 check("in_ready_in_reset", {63'h0, in_ready}, 64'h0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_cpu_hold",  {63'h0, cpu_hold}, 64'h1);
        check("rst_done",      {63'h0, done},     64'h0);
        check("rst_err",       {63'h0, err},      64'h0);
        check("rst_mem_we",    {63'h0, mem_we},   64'h0);
        check("rst_mem_addr",  {54'h0, mem_addr}, 64'h0);
        check("rst_mem_wdata", {32'h0, mem_wdata}, 64'h0);
        check("rst_in_ready",  {63'h0, in_ready}, 64'h1);
    endtask

    task automatic send_image(input int n, input logic [7:0] chk, input bit toggle);
        logic [15:0] nn;
        logic [31:0] w;
        nn = 16'(n);
        send_byte(nn[15:8]);
        if (toggle) idle(1);
        send_byte(nn[7:0]);
        if (toggle) idle(1);
        for (int i = 0; i < n; i++) begin
            w = img[i];
            exp_q.push_back({ADDR_W'(i), w});
            for (int k = 3; k >= 0; k--) begin
                send_byte(w[k*8 +: 8]);
                if (toggle) idle(1);
            end
        end
        send_byte(chk);
    endtask

    task automatic load_s1();
        img[0] = 32'h2002_0005;
        img[1] = 32'h2003_000C;
        img[2] = 32'h2067_FFF7;
    endtask

    task automatic expect_result(input string tag, input logic d, input logic e);
        check({tag, "_done"},     {63'h0, done},     {63'h0, d});
        check({tag, "_err"},      {63'h0, err},      {63'h0, e});
        check({tag, "_cpu_hold"}, {63'h0, cpu_hold}, {63'h0, ~d});
        check({tag, "_in_ready"}, {63'h0, in_ready}, 64'h0);
        check({tag, "_writes_drained"}, 64'(exp_q.size()), 64'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst      = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        @(negedge clk);
        do_reset();

        // three-word image, checksum 0x47 computed by hand
        load_s1();
        send_image(3, 8'h47, 1'b0);
        expect_result("s1", 1'b1, 1'b0);
        offer_refused(8'h00, 3);

        // reset while DONE
        do_reset();

        // same image with in_valid toggling every cycle
        load_s1();
        send_image(3, 8'h47, 1'b1);
        expect_result("s2", 1'b1, 1'b0);

        // empty image, good and bad checksum
        do_reset();
        send_image(0, 8'h00, 1'b0);
        expect_result("s3_empty_ok", 1'b1, 1'b0);
        do_reset();
        send_image(0, 8'h5A, 1'b0);
        expect_result("s3_empty_bad", 1'b0, 1'b1);

        // oversized header 0x0401
        do_reset();
        send_byte(8'h04);
        send_byte(8'h01);
        expect_result("s4_overflow", 1'b0, 1'b1);
        offer_refused(8'h20, 4);
        check("s4_err_sticky", {63'h0, err}, 64'h1);

        // corrupted checksum: writes still happen, then error
        do_reset();
        load_s1();
        send_image(3, 8'h46, 1'b0);
        expect_result("s5_badchk", 1'b0, 1'b1);

        // reset after 6 data bytes, then a full clean load
        do_reset();
        exp_q.push_back({ADDR_W'(0), 32'h2002_0005});
        send_byte(8'h00); send_byte(8'h03);
        send_byte(8'h20); send_byte(8'h02); send_byte(8'h00); send_byte(8'h05);
        send_byte(8'h20); send_byte(8'h03);
        idle(1);
        check("s6_first_word_written", 64'(exp_q.size()), 64'h0);
        do_reset();
        load_s1();
        send_image(3, 8'h47, 1'b0);
        expect_result("s6_reload", 1'b1, 1'b0);

        // full-capacity image: last write lands at 0x3FF; checksum of this pattern is 0x00
        do_reset();
        for (int i = 0; i < 1024; i++) img[i] = 32'hA500_0000 | 32'(i);
        send_image(1024, 8'h00, 1'b0);
        expect_result("s7_full", 1'b1, 1'b0);
        check("s7_last_addr", {54'h0, mem_addr}, 64'h3FF);

        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
